gfx_blender_modes: RTL and testbench
====================================

Name: gfx_blender_modes

Overview:
Per-pixel blend stage between the fragment stage and the render stage. It generalises alpha blending to four selectable blend modes and uses an exactly rounded combined alpha. Opaque pixels skip the target read, and fully transparent pixels can be discarded. Target pixels are fetched through the wishbone-master reader port; the blended pixel is handed on with a level write/ack handshake.

Parameters:
point_width, 16, width of the x/y/z and target size fields
fast_opaque, 1, when 1: alpha mode with a==255 skips the target read

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
blending_enable_i  in  1  0 = pass-through
blend_mode_i  in  2  00 alpha, 01 additive, 10 multiply, 11 subtract
discard_transparent_i  in  1  drop pixels with a==0 (alpha mode only)
target_base_i  in  30  [31:2] word base address of the target surface
target_size_x_i  in  point_width  target width in pixels
target_size_y_i  in  point_width  target height in pixels (unused; kept for interface parity)
color_depth_i  in  2  00 8bpp gray, 01 16bpp 565, 1x 32bpp xRGB
x_counter_i, y_counter_i  in  point_width  pixel coordinates
z_i  in  point_width  signed depth
alpha_i, global_alpha_i  in  8  per-pixel and global alpha
pixel_color_i  in  32  source color, right-aligned
write_i  in  1  pixel valid (sampled in IDLE only)
ack_o  out  1  one-cycle pulse: pixel completed
target_request_o  out  1  read request to the reader
target_addr_o  out  30  [31:2] word address of the target pixel
target_sel_o  out  4  byte select, constant 4'b1111
target_data_i  in  32  read data from the reader
target_ack_i  in  1  read complete
wbm_busy_i  in  1  reader busy
pixel_x_o, pixel_y_o, pixel_z_o  out  point_width  pixel coordinates to render
pixel_color_o  out  32  blended color, right-aligned
write_o  out  1  level request to render
ack_i  in  1  render done

Behaviour:
- Reset (async): state IDLE; all outputs 0 except target_sel_o = 4'b1111. A reset mid-read drops target_request_o immediately; a later stray target_ack_i in IDLE is ignored.
- Capture: in IDLE, write_i=1 latches x, y, z, color, color_depth_i, blend_mode_i, blending_enable_i, discard_transparent_i and p = alpha_i*global_alpha_i (16 bit). Inputs are not sampled again until the next IDLE.
- Combined alpha: a = (q + (q>>8)) >> 8 with q = p + 128 (exact round of p/255). 0xFF*0xFF gives 255; 0 gives 0.
- Channels: 8bpp = one 8-bit channel; 16bpp = r[15:11], g[10:5], b[4:0]; 32bpp = 8/8/8 in [23:0], and output [31:24] copies source [31:24].
- Target sub-word, big-endian: 8bpp: x[1:0]=00 selects [31:24] ... 11 selects [7:0]. 16bpp: x[1]=0 selects [31:16], x[1]=1 selects [15:0].
- Address: off = (size_x*y + x) << {0,1,2} for 8/16/32bpp (32-bit arithmetic); target_addr_o = target_base_i + off[31:2]. It is combinational from the captured coordinates.
- Per channel, with channel max M = 2^w - 1 and R(t) = ((t+128) + ((t+128)>>8)) >> 8:
  - alpha: R(s*a + d*(255-a))
  - additive: min(d + R(s*a), M)
  - multiply: (s*(d+1)) >> w
  - subtract: max(d - R(s*a), 0)
  - Intermediates are 17 bits wide; there is no overflow.
- FSM:
  - IDLE: on write_i go to DECIDE.
  - DECIDE:
    - Blending disabled, or (alpha mode, fast_opaque, a==255): go to WRITE with the source color unchanged.
    - Alpha mode, discard, a==0: go to DONE.
    - Otherwise go to READ.
  - READ:
    - target_request_o <= target_request_o | !wbm_busy_i.
    - On target_ack_i: latch target_data_i, clear the request, go to CALC.
  - CALC: register the blended color, go to WRITE.
  - WRITE:
    - write_o and pixel outputs are valid from entry and held until ack_i.
    - On ack_i: write_o <= 0, go to DONE.
  - DONE: ack_o = 1 for one cycle, go to IDLE.
- Latency (write_i to write_o rise): bypass 2 cycles; blended path 3 cycles plus read latency.
- Simultaneous target_ack_i and wbm_busy_i: the ack wins.

Test Plan:
- Blend disabled, 32bpp, color 0x11223344 → write_o rises 2 cycles after write_i with color 0x11223344; no target_request_o; ack_i → ack_o pulse the next cycle.
- Alpha mode, 32bpp, alpha_i=0x80, global=0xFF (a=128), src 0x00FF0000, dst 0x000000FF → pixel_color_o 0x0080007F.
- Alpha mode, alpha_i=global=0xFF, fast_opaque=1 → no target_request_o, source color written; with fast_opaque=0 a read occurs and the result still equals the source.
- Additive, 16bpp, a=255, base word 0x1000, size_x 640, x=3, y=2, src 0x0841, target_data_i[15:0]=0xFFFF → target_addr_o 0x1281, pixel_color_o 0x0000FFFF.
- Alpha mode, a=0, discard=1 → ack_o 2 cycles after write_i; write_o and target_request_o never assert.
- wbm_busy_i held 3 cycles in READ → request asserts the cycle after busy falls; rst_i pulse while requesting → all outputs 0 immediately, FSM in IDLE, a subsequent pixel completes normally.

Source files
------------

// File: rtl/gfx_blender_modes.sv
// gfx_blender_modes: per-pixel blend stage (alpha/add/mul/sub) ahead of render.
// Ports: fragment in (write_i/ack_o), target reader (request/ack), render out (write_o/ack_i).
module gfx_blender_modes #(
  parameter int point_width = 16,
  parameter bit fast_opaque = 1'b1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   blending_enable_i,
  input  logic [1:0]             blend_mode_i,
  input  logic                   discard_transparent_i,
  input  logic [31:2]            target_base_i,
  input  logic [point_width-1:0] target_size_x_i,
  input  logic [point_width-1:0] target_size_y_i,
  input  logic [1:0]             color_depth_i,
  input  logic [point_width-1:0] x_counter_i,
  input  logic [point_width-1:0] y_counter_i,
  input  logic [point_width-1:0] z_i,
  input  logic [7:0]             alpha_i,
  input  logic [7:0]             global_alpha_i,
  input  logic [31:0]            pixel_color_i,
  input  logic                   write_i,
  output logic                   ack_o,
  output logic                   target_request_o,
  output logic [31:2]            target_addr_o,
  output logic [3:0]             target_sel_o,
  input  logic [31:0]            target_data_i,
  input  logic                   target_ack_i,
  input  logic                   wbm_busy_i,
  output logic [point_width-1:0] pixel_x_o,
  output logic [point_width-1:0] pixel_y_o,
  output logic [point_width-1:0] pixel_z_o,
  output logic [31:0]            pixel_color_o,
  output logic                   write_o,
  input  logic                   ack_i
);

  typedef enum logic [2:0] {
    S_IDLE, S_DECIDE, S_READ, S_CALC, S_WRITE, S_DONE
  } state_t;

  state_t r_state, w_next;

  logic [point_width-1:0] r_x, r_y, r_z;
  logic [31:0] r_src, r_dst, r_out;
  logic [1:0]  r_depth, r_mode;
  logic        r_en, r_disc, r_req, r_write;
  logic [15:0] r_p;

  // Exact round of p/255.
  function automatic logic [16:0] f_rnd(input logic [16:0] t);
    logic [16:0] u;
    u = t + 17'd128;
    return (u + (u >> 8)) >> 8;
  endfunction

  function automatic logic [7:0] f_ch(
    input logic [1:0] m,
    input logic [7:0] s,
    input logic [7:0] d,
    input logic [7:0] a,
    input logic [3:0] w
  );
    logic [16:0] mx, sa, sum, res;
    mx  = (17'd1 << w) - 17'd1;
    sa  = f_rnd(17'(s) * 17'(a));
    sum = 17'(d) + sa;
    res = '0;
    unique case (m)
      2'b00: res = f_rnd(17'(s) * 17'(a) + 17'(d) * 17'(8'd255 - a));
      2'b01: res = (sum > mx) ? mx : sum;
      2'b10: res = (17'(s) * (17'(d) + 17'd1)) >> w;
      default: res = (17'(d) >= sa) ? 17'(d) - sa : 17'd0;
    endcase
    return res[7:0];
  endfunction

  logic [16:0] w_q, w_a17;
  logic [7:0]  w_a;
  assign w_q   = {1'b0, r_p} + 17'd128;
  assign w_a17 = (w_q + (w_q >> 8)) >> 8;
  assign w_a   = w_a17[7:0];

  logic [7:0]  w_d8;
  logic [15:0] w_d16;
  always_comb begin
    w_d8 = r_dst[31:24];
    unique case (r_x[1:0])
      2'b00: w_d8 = r_dst[31:24];
      2'b01: w_d8 = r_dst[23:16];
      2'b10: w_d8 = r_dst[15:8];
      default: w_d8 = r_dst[7:0];
    endcase
    w_d16 = r_x[1] ? r_dst[15:0] : r_dst[31:16];
  end

  logic [7:0] w_y8, w_r16, w_g16, w_b16, w_r32, w_g32, w_b32;
  assign w_y8  = f_ch(r_mode, r_src[7:0], w_d8, w_a, 4'd8);
  assign w_r16 = f_ch(r_mode, {3'b0, r_src[15:11]},
                      {3'b0, w_d16[15:11]}, w_a, 4'd5);
  assign w_g16 = f_ch(r_mode, {2'b0, r_src[10:5]},
                      {2'b0, w_d16[10:5]}, w_a, 4'd6);
  assign w_b16 = f_ch(r_mode, {3'b0, r_src[4:0]},
                      {3'b0, w_d16[4:0]}, w_a, 4'd5);
  assign w_r32 = f_ch(r_mode, r_src[23:16], r_dst[23:16], w_a, 4'd8);
  assign w_g32 = f_ch(r_mode, r_src[15:8], r_dst[15:8], w_a, 4'd8);
  assign w_b32 = f_ch(r_mode, r_src[7:0], r_dst[7:0], w_a, 4'd8);

  logic [31:0] w_blend;
  always_comb begin
    w_blend = {24'b0, w_y8};
    if (r_depth[1])
      w_blend = {r_src[31:24], w_r32, w_g32, w_b32};
    else if (r_depth[0])
      w_blend = {16'b0, w_r16[4:0], w_g16[5:0], w_b16[4:0]};
  end

  logic [31:0] w_lin, w_off;
  assign w_lin = 32'(target_size_x_i) * 32'(r_y) + 32'(r_x);
  always_comb begin
    w_off = w_lin;
    if (r_depth[1])
      w_off = w_lin << 2;
    else if (r_depth[0])
      w_off = w_lin << 1;
  end

  logic w_bypass, w_drop;
  assign w_bypass = !r_en ||
                    (r_mode == 2'b00 && fast_opaque && w_a == 8'd255);
  assign w_drop   = r_mode == 2'b00 && r_disc && w_a == 8'd0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (write_i) w_next = S_DECIDE;
      S_DECIDE: begin
        if (w_bypass)    w_next = S_WRITE;
        else if (w_drop) w_next = S_DONE;
        else             w_next = S_READ;
      end
      S_READ:   if (target_ack_i) w_next = S_CALC;
      S_CALC:   w_next = S_WRITE;
      S_WRITE:  if (ack_i) w_next = S_DONE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_x     <= '0;
      r_y     <= '0;
      r_z     <= '0;
      r_src   <= '0;
      r_dst   <= '0;
      r_out   <= '0;
      r_depth <= '0;
      r_mode  <= '0;
      r_en    <= 1'b0;
      r_disc  <= 1'b0;
      r_req   <= 1'b0;
      r_write <= 1'b0;
      r_p     <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: if (write_i) begin
          r_x     <= x_counter_i;
          r_y     <= y_counter_i;
          r_z     <= z_i;
          r_src   <= pixel_color_i;
          r_depth <= color_depth_i;
          r_mode  <= blend_mode_i;
          r_en    <= blending_enable_i;
          r_disc  <= discard_transparent_i;
          r_p     <= 16'(alpha_i) * 16'(global_alpha_i);
        end
        S_DECIDE: if (w_bypass) begin
          r_out   <= r_src;
          r_write <= 1'b1;
        end
        // Ack takes priority over a concurrent busy.
        S_READ: begin
          if (target_ack_i) begin
            r_dst <= target_data_i;
            r_req <= 1'b0;
          end else begin
            r_req <= r_req | !wbm_busy_i;
          end
        end
        S_CALC: begin
          r_out   <= w_blend;
          r_write <= 1'b1;
        end
        S_WRITE: if (ack_i) r_write <= 1'b0;
        default: ;
      endcase
    end
  end

  assign ack_o            = (r_state == S_DONE);
  assign target_request_o = r_req;
  assign target_addr_o    = target_base_i + w_off[31:2];
  assign target_sel_o     = 4'b1111;
  assign pixel_x_o        = r_x;
  assign pixel_y_o        = r_y;
  assign pixel_z_o        = r_z;
  assign pixel_color_o    = r_out;
  assign write_o          = r_write;

  logic w_unused;
  assign w_unused = ^{target_size_y_i, w_off[1:0], w_a17[16:8],
                      w_r16[7:5], w_g16[7:6], w_b16[7:5]};

endmodule

// File: tb/tb_gfx_blender_modes.sv
// tb_gfx_blender_modes: directed scoreboard bench for gfx_blender_modes.
// Stimulus pushes expectations; a negedge monitor pops and compares.
module tb_gfx_blender_modes;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        blending_enable_i;
  logic [1:0]  blend_mode_i;
  logic        discard_transparent_i;
  logic [31:2] target_base_i;
  logic [15:0] target_size_x_i;
  logic [15:0] target_size_y_i;
  logic [1:0]  color_depth_i;
  logic [15:0] x_counter_i;
  logic [15:0] y_counter_i;
  logic [15:0] z_i;
  logic [7:0]  alpha_i;
  logic [7:0]  global_alpha_i;
  logic [31:0] pixel_color_i;
  logic        write_i;
  logic        ack_o;
  logic        target_request_o;
  logic [31:2] target_addr_o;
  logic [3:0]  target_sel_o;
  logic [31:0] target_data_i;
  logic        target_ack_i;
  logic        wbm_busy_i;
  logic [15:0] pixel_x_o;
  logic [15:0] pixel_y_o;
  logic [15:0] pixel_z_o;
  logic [31:0] pixel_color_o;
  logic        write_o;
  logic        ack_i;

  always #5 clk_i = ~clk_i;

  gfx_blender_modes #(.point_width(16), .fast_opaque(1'b1)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .blending_enable_i(blending_enable_i),
    .blend_mode_i(blend_mode_i),
    .discard_transparent_i(discard_transparent_i),
    .target_base_i(target_base_i),
    .target_size_x_i(target_size_x_i),
    .target_size_y_i(target_size_y_i),
    .color_depth_i(color_depth_i),
    .x_counter_i(x_counter_i), .y_counter_i(y_counter_i),
    .z_i(z_i), .alpha_i(alpha_i), .global_alpha_i(global_alpha_i),
    .pixel_color_i(pixel_color_i), .write_i(write_i), .ack_o(ack_o),
    .target_request_o(target_request_o), .target_addr_o(target_addr_o),
    .target_sel_o(target_sel_o), .target_data_i(target_data_i),
    .target_ack_i(target_ack_i), .wbm_busy_i(wbm_busy_i),
    .pixel_x_o(pixel_x_o), .pixel_y_o(pixel_y_o), .pixel_z_o(pixel_z_o),
    .pixel_color_o(pixel_color_o), .write_o(write_o), .ack_i(ack_i)
  );

  typedef struct {
    bit          wr;
    logic [31:0] color;
    logic [15:0] x;
    logic [15:0] y;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          pend = 0;
  bit          saw_req = 0;
  bit          rd_en = 0;
  bit          stray = 0;
  int          rd_lat = 1;
  int          rd_cnt = 0;
  logic [31:0] tgt_data = '0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, req);
    end
  endtask

  function automatic bit sig_of(input int w);
    case (w)
      0: return write_o;
      1: return ack_o;
      default: return target_request_o;
    endcase
  endfunction

  // Counts negedges (continuing from n0) until the signal is high.
  task automatic wait_sig(input int w, input int n0, input int lim,
                          output int n);
    n = n0;
    while (!sig_of(w) && n < lim) begin
      @(negedge clk_i);
      n++;
    end
    if (!sig_of(w)) n = -1;
  endtask

  // Monitor / scoreboard.
  always @(negedge clk_i) begin
    if (target_request_o) saw_req = 1;
    if (rst_i) begin
      pend = 0;
    end else begin
      if (write_o && !pend) begin
        pend = 1;
        if (exp_q.size() == 0) begin
          chk("sb_empty_wr", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("sb_kind_wr", {31'b0, e.wr}, 32'd1);
          chk("sb_color", pixel_color_o, e.color);
          chk("sb_x", {16'b0, pixel_x_o}, {16'b0, e.x});
          chk("sb_y", {16'b0, pixel_y_o}, {16'b0, e.y});
        end
      end
      if (ack_o) begin
        if (pend) begin
          pend = 0;
        end else if (exp_q.size() == 0) begin
          chk("sb_empty_ack", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("sb_kind_ack", {31'b0, e.wr}, 32'd0);
        end
      end
    end
  end

  // Render side: acknowledge a pending write one cycle.
  always @(negedge clk_i) begin
    if (write_o && !ack_i) ack_i = 1'b1;
    else                   ack_i = 1'b0;
  end

  // Target reader model.
  always @(negedge clk_i) begin
    target_ack_i = 1'b0;
    if (stray) begin
      target_ack_i = 1'b1;
    end else if (rd_en && target_request_o) begin
      if (rd_cnt >= rd_lat) begin
        target_ack_i  = 1'b1;
        target_data_i = tgt_data;
        rd_cnt = 0;
      end else begin
        rd_cnt++;
      end
    end else begin
      rd_cnt = 0;
    end
  end

  task automatic issue(input logic en, input logic [1:0] mode,
                       input logic disc, input logic [1:0] dep,
                       input logic [15:0] x, input logic [15:0] y,
                       input logic [7:0] al, input logic [7:0] ga,
                       input logic [31:0] col);
    @(negedge clk_i);
    blending_enable_i     = en;
    blend_mode_i          = mode;
    discard_transparent_i = disc;
    color_depth_i         = dep;
    x_counter_i           = x;
    y_counter_i           = y;
    z_i                   = x ^ y;
    alpha_i               = al;
    global_alpha_i        = ga;
    pixel_color_i         = col;
    write_i               = 1'b1;
    @(negedge clk_i);
    write_i = 1'b0;
  endtask

  task automatic push(input bit wr, input logic [31:0] c,
                      input logic [15:0] x, input logic [15:0] y);
    exp_t t;
    t.wr = wr; t.color = c; t.x = x; t.y = y;
    exp_q.push_back(t);
  endtask

  task automatic finish_px(input int n0);
    int n;
    wait_sig(1, n0, n0 + 40, n);
    if (n < 0) chk("ack_timeout", 32'hFFFF_FFFF, 32'd0);
    repeat (2) @(negedge clk_i);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1);
  end

  initial begin
    int n;
    rst_i = 1'b1;
    blending_enable_i = 0; blend_mode_i = 0; discard_transparent_i = 0;
    target_base_i = '0; target_size_x_i = 16'd640; target_size_y_i = 16'd480;
    color_depth_i = 0; x_counter_i = 0; y_counter_i = 0; z_i = 0;
    alpha_i = 0; global_alpha_i = 0; pixel_color_i = 0; write_i = 0;
    target_data_i = 0; target_ack_i = 0; wbm_busy_i = 0; ack_i = 0;
    repeat (3) @(negedge clk_i);
    chk("rst_write", {31'b0, write_o}, 32'd0);
    chk("rst_ack", {31'b0, ack_o}, 32'd0);
    chk("rst_req", {31'b0, target_request_o}, 32'd0);
    chk("rst_sel", {28'b0, target_sel_o}, 32'hF);
    chk("rst_color", pixel_color_o, 32'd0);
    chk("rst_addr", {2'b0, target_addr_o}, 32'd0);
    rst_i = 1'b0;
    repeat (2) @(negedge clk_i);

    // Pass-through.
    saw_req = 0;
    push(1, 32'h11223344, 16'd5, 16'd7);
    issue(0, 2'b00, 0, 2'b10, 16'd5, 16'd7, 8'hFF, 8'hFF, 32'h11223344);
    wait_sig(0, 1, 20, n);
    chk("bypass_lat", 32'(n), 32'd2);
    wait_sig(1, n, 20, n);
    chk("bypass_ack_lat", 32'(n), 32'd3);
    chk("bypass_noreq", {31'b0, saw_req}, 32'd0);
    repeat (2) @(negedge clk_i);

    // Alpha blend, a=128.
    rd_en = 1; tgt_data = 32'h000000FF;
    push(1, 32'h0080007F, 16'd10, 16'd1);
    issue(1, 2'b00, 0, 2'b10, 16'd10, 16'd1, 8'h80, 8'hFF, 32'h00FF0000);
    wait_sig(0, 1, 30, n);
    chk("alpha_lat", 32'(n), 32'd6);
    finish_px(n);

    // Opaque fast path.
    saw_req = 0;
    push(1, 32'h00123456, 16'd2, 16'd3);
    issue(1, 2'b00, 0, 2'b10, 16'd2, 16'd3, 8'hFF, 8'hFF, 32'h00123456);
    wait_sig(0, 1, 20, n);
    chk("opaque_lat", 32'(n), 32'd2);
    finish_px(n);
    chk("opaque_noreq", {31'b0, saw_req}, 32'd0);

    // Additive 16bpp with saturation and address check.
    target_base_i = 30'h1000; tgt_data = 32'h0000FFFF;
    push(1, 32'h0000FFFF, 16'd3, 16'd2);
    issue(1, 2'b01, 0, 2'b01, 16'd3, 16'd2, 8'hFF, 8'hFF, 32'h00000841);
    wait_sig(2, 1, 20, n);
    chk("add_addr", {2'b0, target_addr_o}, 32'h1281);
    wait_sig(0, n, 40, n);
    finish_px(n);

    // Discard transparent.
    saw_req = 0;
    push(0, 32'h0, 16'd0, 16'd0);
    issue(1, 2'b00, 1, 2'b10, 16'd4, 16'd4, 8'h00, 8'h55, 32'hDEADBEEF);
    wait_sig(1, 1, 20, n);
    chk("discard_ack_lat", 32'(n), 32'd2);
    chk("discard_noreq", {31'b0, saw_req}, 32'd0);
    repeat (3) @(negedge clk_i);

    // Multiply 8bpp, x[1:0]=01 selects bits [23:16].
    tgt_data = 32'h11C83344;
    push(1, 32'h00000064, 16'd1, 16'd0);
    issue(1, 2'b10, 0, 2'b00, 16'd1, 16'd0, 8'hFF, 8'hFF, 32'h00000080);
    wait_sig(0, 1, 40, n);
    finish_px(n);

    // Subtract 32bpp with a clamped channel.
    tgt_data = 32'h00300850;
    push(1, 32'hAB280038, 16'd9, 16'd9);
    issue(1, 2'b11, 0, 2'b10, 16'd9, 16'd9, 8'hFF, 8'h80, 32'hAB102030);
    wait_sig(0, 1, 40, n);
    finish_px(n);

    // Busy held during READ; then ack arrives while busy.
    tgt_data = 32'h00445566; wbm_busy_i = 1;
    push(1, 32'h99445566, 16'd6, 16'd8);
    issue(1, 2'b00, 0, 2'b10, 16'd6, 16'd8, 8'h00, 8'hFF, 32'h99000000);
    repeat (3) begin
      @(negedge clk_i);
      chk("busy_noreq", {31'b0, target_request_o}, 32'd0);
    end
    @(negedge clk_i);
    chk("busy_last", {31'b0, target_request_o}, 32'd0);
    wbm_busy_i = 0;
    @(negedge clk_i);
    chk("busy_req_rise", {31'b0, target_request_o}, 32'd1);
    wbm_busy_i = 1;
    wait_sig(0, 1, 40, n);
    wbm_busy_i = 0;
    finish_px(n);

    // Reset while requesting; no expectation for the aborted pixel.
    rd_en = 0;
    issue(1, 2'b00, 0, 2'b10, 16'd12, 16'd13, 8'h80, 8'h80, 32'h00FFFFFF);
    wait_sig(2, 1, 20, n);
    chk("pre_rst_req", {31'b0, target_request_o}, 32'd1);
    rst_i = 1'b1;
    #1;
    chk("mid_rst_req", {31'b0, target_request_o}, 32'd0);
    chk("mid_rst_write", {31'b0, write_o}, 32'd0);
    chk("mid_rst_ack", {31'b0, ack_o}, 32'd0);
    chk("mid_rst_x", {16'b0, pixel_x_o}, 32'd0);
    chk("mid_rst_sel", {28'b0, target_sel_o}, 32'hF);
    @(negedge clk_i);
    rst_i = 1'b0;
    stray = 1;
    @(negedge clk_i);
    stray = 0;
    repeat (2) @(negedge clk_i);
    chk("stray_ack_o", {31'b0, ack_o}, 32'd0);
    chk("stray_write_o", {31'b0, write_o}, 32'd0);

    // Normal pixel after reset.
    push(1, 32'hCAFEBABE, 16'd20, 16'd21);
    issue(0, 2'b00, 0, 2'b10, 16'd20, 16'd21, 8'h10, 8'h10, 32'hCAFEBABE);
    wait_sig(0, 1, 20, n);
    chk("post_rst_lat", 32'(n), 32'd2);
    finish_px(n);

    repeat (4) @(negedge clk_i);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
